// File: rtl/mux_nx1_rr.sv
// Registered N:1 multiplexer with a rotating-priority arbiter and valid/ready on every channel.
// Optional build macro MUX_RR_MANUAL_EN adds mode/sel ports that bypass the arbiter.
module mux_nx1_rr #(
    parameter int N = 8,
    parameter int W = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N*W-1:0]    in_data,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_sel,
    output logic              out_valid,
    input  logic              out_ready
`ifdef MUX_RR_MANUAL_EN
    ,
    input  logic              mode,
    input  logic [SELW-1:0]   sel
`endif
);

    logic [SELW-1:0] ptr_r;
    logic [W-1:0]    out_data_r;
    logic [SELW-1:0] out_sel_r;
    logic            out_valid_r;

    logic            load_s;
    logic            any_s;
    logic            xfer_s;
    logic            manual_s;
    logic            ready_hit_s;
    logic [SELW:0]   cand_s;
    logic [SELW-1:0] rr_grant_s;
    logic [SELW-1:0] grant_s;
    logic [SELW-1:0] next_ptr_s;
    logic [W-1:0]    sel_data_s;
    logic [N-1:0]    in_ready_s;

`ifdef MUX_RR_MANUAL_EN
    logic            sel_ok_s;

    // Out-of-range select only exists when N is not a power of two.
    if (N == (1 << SELW)) begin : g_sel_pow2
        assign sel_ok_s = 1'b1;
    end else begin : g_sel_npow2
        assign sel_ok_s = ({1'b0, sel} < (SELW+1)'(N));
    end
`endif

    // Rotating-priority search: first valid channel at or after ptr_r, with wrap.
    always_comb begin
        rr_grant_s = '0;
        any_s      = 1'b0;
        cand_s     = '0;
        for (int i = 0; i < N; i++) begin
            cand_s = {1'b0, ptr_r} + (SELW+1)'(i);
            if (cand_s >= (SELW+1)'(N)) begin
                cand_s = cand_s - (SELW+1)'(N);
            end else begin
                cand_s = cand_s;
            end
            if (!any_s && in_valid[cand_s[SELW-1:0]]) begin
                any_s      = 1'b1;
                rr_grant_s = cand_s[SELW-1:0];
            end else begin
                any_s      = any_s;
            end
        end
    end

    // Grant selection, transfer qualification and per-channel ready.
    always_comb begin
        load_s      = !out_valid_r || out_ready;
        grant_s     = rr_grant_s;
        manual_s    = 1'b0;
        xfer_s      = load_s && any_s;
        ready_hit_s = xfer_s;
`ifdef MUX_RR_MANUAL_EN
        if (mode) begin
            manual_s    = 1'b1;
            grant_s     = sel;
            ready_hit_s = load_s && sel_ok_s;
            xfer_s      = load_s && sel_ok_s && in_valid[sel];
        end else begin
            manual_s    = 1'b0;
        end
`endif
        in_ready_s = '0;
        if (ready_hit_s && rst_n) begin
            in_ready_s[grant_s] = 1'b1;
        end else begin
            in_ready_s = '0;
        end
    end

    // Word mux and next pointer; in_data feeds only the output register.
    always_comb begin
        sel_data_s = '0;
        for (int k = 0; k < N; k++) begin
            if (grant_s == SELW'(k)) begin
                sel_data_s = in_data[k*W +: W];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
        if (rr_grant_s == SELW'(N-1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = rr_grant_s + {{(SELW-1){1'b0}}, 1'b1};
        end
    end

    // Output register and arbiter pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= '0;
            out_sel_r   <= '0;
            out_valid_r <= 1'b0;
            ptr_r       <= '0;
        end else if (load_s) begin
            if (xfer_s) begin
                out_data_r  <= sel_data_s;
                out_sel_r   <= grant_s;
                out_valid_r <= 1'b1;
                if (!manual_s) begin
                    ptr_r <= next_ptr_s;
                end else begin
                    ptr_r <= ptr_r;
                end
            end else begin
                out_valid_r <= 1'b0;
            end
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;
    assign out_valid = out_valid_r;

endmodule
